// File: rtl/floo_reduction_alu.sv
// Integer SIMD reduction ALU: lane-wise add/mul/min/max with an elastic,
// bubble-collapsing output pipeline that preserves operand order.
package floo_reduction_pkg;
    typedef enum logic [3:0] {
        F_Add, F_Mul, F_Max, F_Min,
        A_Add, A_Mul, A_Min_S, A_Min_U, A_Max_S, A_Max_U,
        SeqAW, SeqB, SelectAW, LSBAnd
    } collect_op_e;
endpackage

module floo_reduction_alu
    import floo_reduction_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ElemWidth = 32,
    parameter int unsigned NumStages = 1,
    parameter type reduction_data_t = logic [DataWidth-1:0]
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            operands_valid_i,
    output logic            operands_ready_o,
    input  reduction_data_t operand1_i,
    input  reduction_data_t operand2_i,
    input  collect_op_e     operation_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output reduction_data_t result_o,
    output logic            unsupported_op_o,
    output logic            busy_o
);
    localparam int unsigned NumLanes = DataWidth / ElemWidth;

    reduction_data_t      comp_data_c;
    logic                 comp_unsup_c;
    logic [ElemWidth-1:0] lane_a, lane_b, lane_r;

    // Lane-wise compute; unsupported ops pass operand1 through untouched.
    always_comb begin
        comp_data_c  = operand1_i;
        comp_unsup_c = 1'b0;
        lane_a       = '0;
        lane_b       = '0;
        lane_r       = '0;
        for (int unsigned l = 0; l < NumLanes; l++) begin
            lane_a = operand1_i[l*ElemWidth +: ElemWidth];
            lane_b = operand2_i[l*ElemWidth +: ElemWidth];
            case (operation_i)
                A_Add:   lane_r = lane_a + lane_b;
                A_Mul:   lane_r = lane_a * lane_b;
                A_Min_S: lane_r = ($signed(lane_a) < $signed(lane_b)) ? lane_a : lane_b;
                A_Max_S: lane_r = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
                A_Min_U: lane_r = (lane_a < lane_b) ? lane_a : lane_b;
                A_Max_U: lane_r = (lane_a > lane_b) ? lane_a : lane_b;
                default: lane_r = lane_a;
            endcase
            comp_data_c[l*ElemWidth +: ElemWidth] = lane_r;
        end
        comp_unsup_c = !(operation_i inside {A_Add, A_Mul, A_Min_S, A_Min_U, A_Max_S, A_Max_U});
    end

    if (NumStages == 0) begin : gen_comb
        assign result_valid_o   = operands_valid_i;
        assign operands_ready_o = result_ready_i;
        assign result_o         = comp_data_c;
        assign unsupported_op_o = comp_unsup_c;
        assign busy_o           = 1'b0;
    end else begin : gen_pipe
        logic [NumStages-1:0] valid_q, unsup_q, in_valid, in_unsup;
        logic [NumStages:0]   ready;
        reduction_data_t      data_q  [NumStages];
        reduction_data_t      in_data [NumStages];

        // Ready ripples back from the consumer; an empty stage always accepts.
        always_comb begin
            ready            = '0;
            ready[NumStages] = result_ready_i;
            for (int k = int'(NumStages) - 1; k >= 0; k--) begin
                ready[k] = ~valid_q[k] | ready[k+1];
            end
        end

        always_comb begin
            in_valid    = '0;
            in_unsup    = '0;
            in_valid[0] = operands_valid_i;
            in_unsup[0] = comp_unsup_c;
            in_data[0]  = comp_data_c;
            for (int unsigned k = 1; k < NumStages; k++) begin
                in_valid[k] = valid_q[k-1];
                in_unsup[k] = unsup_q[k-1];
                in_data[k]  = data_q[k-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                unsup_q <= '0;
                for (int unsigned k = 0; k < NumStages; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                for (int unsigned k = 0; k < NumStages; k++) begin
                    if (ready[k]) begin
                        valid_q[k] <= in_valid[k];
                        if (in_valid[k]) begin
                            data_q[k]  <= in_data[k];
                            unsup_q[k] <= in_unsup[k];
                        end
                    end
                end
            end
        end

        assign operands_ready_o = ready[0];
        assign result_valid_o   = valid_q[NumStages-1];
        assign result_o         = data_q[NumStages-1];
        assign unsupported_op_o = unsup_q[NumStages-1];
        assign busy_o           = |valid_q;

        a_result_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (result_valid_o && !result_ready_i) |=> (result_valid_o && $stable(result_o)))
            else $error("result changed while stalled");
    end

    a_lane_div: assert property (@(posedge clk_i) (DataWidth % ElemWidth) == 0)
        else $error("DataWidth must be a multiple of ElemWidth");

endmodule

// File: tb/tb_floo_reduction_alu.sv
// Randomized self-checking bench for floo_reduction_alu at NumStages 1, 2, 3 and 0.
module tb_floo_reduction_alu;
    import floo_reduction_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        vin     [4];
    logic        rdy_out [4];
    logic [63:0] op1     [4];
    logic [63:0] op2     [4];
    collect_op_e op      [4];
    logic        vout    [4];
    logic        rready  [4];
    logic [63:0] res     [4];
    logic        unsup   [4];
    logic        busy    [4];

    int passed = 0;
    int total  = 0;

    floo_reduction_alu #(.DataWidth(64), .ElemWidth(32), .NumStages(1)) u_dut_s1 (
        .clk_i(clk), .rst_ni(rst_n), .operands_valid_i(vin[0]), .operands_ready_o(rdy_out[0]),
        .operand1_i(op1[0]), .operand2_i(op2[0]), .operation_i(op[0]), .result_valid_o(vout[0]),
        .result_ready_i(rready[0]), .result_o(res[0]), .unsupported_op_o(unsup[0]), .busy_o(busy[0]));
    floo_reduction_alu #(.DataWidth(64), .ElemWidth(32), .NumStages(2)) u_dut_s2 (
        .clk_i(clk), .rst_ni(rst_n), .operands_valid_i(vin[1]), .operands_ready_o(rdy_out[1]),
        .operand1_i(op1[1]), .operand2_i(op2[1]), .operation_i(op[1]), .result_valid_o(vout[1]),
        .result_ready_i(rready[1]), .result_o(res[1]), .unsupported_op_o(unsup[1]), .busy_o(busy[1]));
    floo_reduction_alu #(.DataWidth(64), .ElemWidth(32), .NumStages(3)) u_dut_s3 (
        .clk_i(clk), .rst_ni(rst_n), .operands_valid_i(vin[2]), .operands_ready_o(rdy_out[2]),
        .operand1_i(op1[2]), .operand2_i(op2[2]), .operation_i(op[2]), .result_valid_o(vout[2]),
        .result_ready_i(rready[2]), .result_o(res[2]), .unsupported_op_o(unsup[2]), .busy_o(busy[2]));
    floo_reduction_alu #(.DataWidth(64), .ElemWidth(32), .NumStages(0)) u_dut_s0 (
        .clk_i(clk), .rst_ni(rst_n), .operands_valid_i(vin[3]), .operands_ready_o(rdy_out[3]),
        .operand1_i(op1[3]), .operand2_i(op2[3]), .operation_i(op[3]), .result_valid_o(vout[3]),
        .result_ready_i(rready[3]), .result_o(res[3]), .unsupported_op_o(unsup[3]), .busy_o(busy[3]));

    // Reference: each 32-bit lane treated as plain integers; {unsupported, result}.
    function automatic logic [64:0] ref_model(collect_op_e o, logic [63:0] a, logic [63:0] b);
        logic [63:0]     r;
        logic            u;
        longint unsigned x, y;
        int              sx, sy;
        r = a;
        u = !(o inside {A_Add, A_Mul, A_Min_S, A_Min_U, A_Max_S, A_Max_U});
        for (int l = 0; l < 2; l++) begin
            x  = 64'(a[l*32 +: 32]);
            y  = 64'(b[l*32 +: 32]);
            sx = int'(a[l*32 +: 32]);
            sy = int'(b[l*32 +: 32]);
            case (o)
                A_Add:   r[l*32 +: 32] = 32'(x + y);
                A_Mul:   r[l*32 +: 32] = 32'(x * y);
                A_Min_S: r[l*32 +: 32] = (sx <= sy) ? 32'(sx) : 32'(sy);
                A_Max_S: r[l*32 +: 32] = (sx >= sy) ? 32'(sx) : 32'(sy);
                A_Min_U: r[l*32 +: 32] = 32'((x <= y) ? x : y);
                A_Max_U: r[l*32 +: 32] = 32'((x >= y) ? x : y);
                default: ;
            endcase
        end
        return {u, r};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic collect_op_e rand_op();
        return collect_op_e'(4'($urandom_range(0, 13)));
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            vin[i]    = 1'b0;
            rready[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b1; op1[i] = rand64(); op2[i] = rand64(); op[i] = A_Add; rready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (vout[i] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b expected 0", i, vout[i]);
            else passed++;
            total++;
            if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]);
            else passed++;
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdy_out[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b expected 1", i, rdy_out[i]);
            else passed++;
        end
        idle_all();
        @(posedge clk); #1;
    endtask

    task automatic test_lane_arith();
        logic [63:0] va [9];
        logic [63:0] vb [9];
        logic [63:0] ve [9];
        logic        vu [9];
        collect_op_e vo [9];
        va = '{64'hFFFFFFFF_00000005, 64'h00010000_00000003, 64'h80000000_00000001,
               64'h80000000_00000001, 64'h80000000_00000001, 64'h80000000_00000001,
               64'h00000000_00001234, 64'h00000000_00000010, 64'h00000007_00000007};
        vb = '{64'h00000001_00000003, 64'h00010000_00000004, 64'h00000001_FFFFFFFF,
               64'h00000001_FFFFFFFF, 64'h00000001_FFFFFFFF, 64'h00000001_FFFFFFFF,
               64'hDEADBEEF_CAFEF00D, 64'h00000000_00000020, 64'h00000007_00000007};
        ve = '{64'h00000000_00000008, 64'h00000000_0000000C, 64'h80000000_FFFFFFFF,
               64'h00000001_00000001, 64'h80000000_FFFFFFFF, 64'h00000001_00000001,
               64'h00000000_00001234, 64'h00000000_00000030, 64'h00000007_00000007};
        vu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vo = '{A_Add, A_Mul, A_Min_S, A_Min_U, A_Max_U, A_Max_S, SeqAW, A_Add, A_Min_U};
        rready[0] = 1'b1;
        for (int t = 0; t < 9; t++) begin
            op1[0] = va[t]; op2[0] = vb[t]; op[0] = vo[t]; vin[0] = 1'b1;
            @(negedge clk);
            total++;
            if (rdy_out[0] !== 1'b1) $display("FAIL lane_ready[%0d]: got %b expected 1", t, rdy_out[0]);
            else passed++;
            @(posedge clk); #1;
            vin[0] = 1'b0;
            op1[0] = rand64();
            @(negedge clk);
            total++;
            if (vout[0] !== 1'b1) $display("FAIL lane_valid[%0d]: got %b expected 1", t, vout[0]);
            else passed++;
            total++;
            if (res[0] !== ve[t]) $display("FAIL lane_result[%0d]: got %h expected %h", t, res[0], ve[t]);
            else passed++;
            total++;
            if (unsup[0] !== vu[t]) $display("FAIL lane_unsup[%0d]: got %b expected %b", t, unsup[0], vu[t]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] exp_q[$];
        logic [64:0] want;
        int          sent = 0;
        int          recv = 0;
        bit          acc;
        vin[2] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            rready[2] = (c >= 6);
            if (!vin[2] && sent < 5) begin
                op1[2] = rand64(); op2[2] = rand64(); op[2] = A_Add; vin[2] = 1'b1;
            end
            @(negedge clk);
            if (c == 3) begin
                total++;
                if (rdy_out[2] !== 1'b0) $display("FAIL bp_ready_drop: got %b expected 0", rdy_out[2]);
                else passed++;
                total++;
                if (sent != 3) $display("FAIL bp_accepted: got %0d expected 3", sent);
                else passed++;
            end
            if (c >= 3 && c < 6) begin
                total++;
                if (vout[2] !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, vout[2]);
                else passed++;
                want = exp_q[0];
                total++;
                if ({unsup[2], res[2]} !== want) $display("FAIL bp_hold_data[%0d]: got %h expected %h", c, {unsup[2], res[2]}, want);
                else passed++;
            end
            acc = 1'b0;
            if (vin[2] && rdy_out[2]) begin
                exp_q.push_back(ref_model(op[2], op1[2], op2[2]));
                sent++;
                acc = 1'b1;
            end
            if (vout[2] && rready[2]) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL bp_extra: got result %h expected none", res[2]);
                else begin
                    want = exp_q.pop_front();
                    if ({unsup[2], res[2]} !== want) $display("FAIL bp_order[%0d]: got %h expected %h", recv, {unsup[2], res[2]}, want);
                    else passed++;
                end
                recv++;
            end
            @(posedge clk); #1;
            if (acc) vin[2] = 1'b0;
        end
        total++;
        if (recv != 5) $display("FAIL bp_count: got %0d expected 5", recv);
        else passed++;
        idle_all();
    endtask

    task automatic test_throughput();
        logic [64:0] exp_q[$];
        logic [64:0] want;
        logic        exp_v;
        int          recv = 0;
        rready[1] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            vin[1] = (c < 20);
            op1[1] = rand64(); op2[1] = rand64(); op[1] = rand_op();
            @(negedge clk);
            if (c < 20) begin
                total++;
                if (rdy_out[1] !== 1'b1) $display("FAIL tp_ready[%0d]: got %b expected 1", c, rdy_out[1]);
                else passed++;
            end
            exp_v = (c >= 2 && c < 22);
            total++;
            if (vout[1] !== exp_v) $display("FAIL tp_valid[%0d]: got %b expected %b", c, vout[1], exp_v);
            else passed++;
            if (vin[1] && rdy_out[1]) exp_q.push_back(ref_model(op[1], op1[1], op2[1]));
            if (vout[1] && rready[1]) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL tp_extra: got result %h expected none", res[1]);
                else begin
                    want = exp_q.pop_front();
                    if ({unsup[1], res[1]} !== want) $display("FAIL tp_data[%0d]: got %h expected %h", recv, {unsup[1], res[1]}, want);
                    else passed++;
                end
                recv++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (recv != 20) $display("FAIL tp_count: got %0d expected 20", recv);
        else passed++;
        idle_all();
    endtask

    task automatic test_random(input int idx);
        logic [64:0] exp_q[$];
        logic [64:0] want;
        bit          acc;
        vin[idx] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rready[idx] = ($urandom_range(0, 9) < 6);
            if (!vin[idx] && c < 300 && $urandom_range(0, 9) < 7) begin
                op1[idx] = rand64(); op2[idx] = rand64(); op[idx] = rand_op(); vin[idx] = 1'b1;
            end
            @(negedge clk);
            acc = 1'b0;
            if (vin[idx] && rdy_out[idx]) begin
                exp_q.push_back(ref_model(op[idx], op1[idx], op2[idx]));
                acc = 1'b1;
            end
            if (vout[idx] && rready[idx]) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL rnd%0d_extra: got result %h expected none", idx, res[idx]);
                else begin
                    want = exp_q.pop_front();
                    if ({unsup[idx], res[idx]} !== want) $display("FAIL rnd%0d_data: got %h expected %h", idx, {unsup[idx], res[idx]}, want);
                    else passed++;
                end
            end
            @(posedge clk); #1;
            if (acc) vin[idx] = 1'b0;
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL rnd%0d_lost: got %0d pending expected 0", idx, exp_q.size());
        else passed++;
        @(negedge clk);
        total++;
        if (busy[idx] !== 1'b0) $display("FAIL rnd%0d_busy: got %b expected 0", idx, busy[idx]);
        else passed++;
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_midflight_reset();
        rready[2] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            op1[2] = rand64(); op2[2] = rand64(); op[2] = A_Add; vin[2] = 1'b1;
            @(posedge clk); #1;
        end
        vin[2] = 1'b0;
        @(negedge clk);
        total++;
        if (busy[2] !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy[2]);
        else passed++;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy[2] !== 1'b0) $display("FAIL mid_busy_reset: got %b expected 0", busy[2]);
        else passed++;
        total++;
        if (vout[2] !== 1'b0) $display("FAIL mid_valid_reset: got %b expected 0", vout[2]);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rready[2] = 1'b1;
        #1;
        total++;
        if (rdy_out[2] !== 1'b1) $display("FAIL mid_ready_after: got %b expected 1", rdy_out[2]);
        else passed++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (vout[2] !== 1'b0) $display("FAIL mid_ghost[%0d]: got %b expected 0", c, vout[2]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vin[i] = 1'b0; op1[i] = '0; op2[i] = '0; op[i] = A_Add; rready[i] = 1'b1;
        end
        test_reset();
        test_lane_arith();
        test_backpressure();
        test_throughput();
        for (int i = 0; i < 4; i++) test_random(i);
        test_midflight_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
